// File: rtl/intbus_traffic_gen_pkg.sv
// Shared types and helpers for the internal-bus traffic generator.
package intbus_traffic_gen_pkg;

   typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

   localparam logic [1:0] MODE_WR    = 2'd0;
   localparam logic [1:0] MODE_RD    = 2'd1;
   localparam logic [1:0] MODE_WR_RD = 2'd2;

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] maxv);
      return (v >= maxv) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/intbus_lat_meter.sv
// Request-to-ack latency counter with saturating worst-case tracker.
module intbus_lat_meter
   import intbus_traffic_gen_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        active,
   input  logic        close,
   output logic [15:0] cur_lat,
   output logic [15:0] max_lat
);

   logic [15:0] lat;

   // cur_lat counts the present REQ cycle, so an ack in the first cycle reads 1
   assign cur_lat = 16'(sat_inc(32'(lat), 32'h0000_FFFF));

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         lat     <= '0;
         max_lat <= '0;
      end else if (close) begin
         lat <= '0;
         if (cur_lat > max_lat) max_lat <= cur_lat;
      end else if (active) begin
         lat <= cur_lat;
      end
   end

endmodule

// File: rtl/intbus_traffic_gen.sv
// Bus-master traffic generator: programmed write/read passes with latency and run-time stats.
// Read-data checking is built only when INTBUS_TRAFFIC_GEN_CHECK_EN is defined.
//   state | meaning
//   IDLE  | waiting for start
//   REQ   | request on bus, waiting for ack
//   GAP   | one idle cycle between transactions
//   DONE  | done pulse, busy drops
module intbus_traffic_gen
   import intbus_traffic_gen_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int CNT_W     = 16,
   parameter int ADDR_STEP = 1,
   parameter int TIMEOUT   = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [CNT_W-1:0]  cfg_count,
   input  logic [1:0]        cfg_mode,
   input  logic [DATA_W-1:0] cfg_seed,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_wr,
   output logic              m_rd,
   input  logic              m_ack,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [15:0]       max_lat,
   output logic [31:0]       total_cycles
);

   state_t            state;
   logic [ADDR_W-1:0] base_r;
   logic [DATA_W-1:0] seed_r;
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  idx;
   logic              rd_pass;
   logic              two_pass;
   logic [15:0]       cur_lat;
   logic              lat_hit;
   logic              last;

   assign lat_hit = 32'(cur_lat) >= 32'(TIMEOUT);
   assign last    = (idx + CNT_W'(1)) == count_r;

`ifndef INTBUS_TRAFFIC_GEN_CHECK_EN
   logic unused_rdata;
   assign unused_rdata = ^m_rdata;
`endif

   intbus_lat_meter u_lat (
      .clk     (clk),
      .reset   (reset),
      .clear   (state == IDLE && start),
      .active  (state == REQ),
      .close   (state == REQ && (m_ack || lat_hit)),
      .cur_lat (cur_lat),
      .max_lat (max_lat)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         base_r       <= '0;
         seed_r       <= '0;
         count_r      <= '0;
         idx          <= '0;
         rd_pass      <= 1'b0;
         two_pass     <= 1'b0;
         m_addr       <= '0;
         m_wdata      <= '0;
         m_wr         <= 1'b0;
         m_rd         <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         timeout      <= 1'b0;
         err_cnt      <= '0;
         total_cycles <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               base_r       <= cfg_base;
               seed_r       <= cfg_seed;
               count_r      <= cfg_count;
               idx          <= '0;
               rd_pass      <= (cfg_mode == MODE_RD);
               two_pass     <= (cfg_mode == MODE_WR_RD);
               m_addr       <= cfg_base;
               m_wdata      <= cfg_seed;
               busy         <= 1'b1;
               timeout      <= 1'b0;
               err_cnt      <= '0;
               total_cycles <= 32'd1;
               if (cfg_count == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state <= REQ;
                  m_wr  <= (cfg_mode != MODE_RD);
                  m_rd  <= (cfg_mode == MODE_RD);
               end
            end
            REQ: begin
               total_cycles <= sat_inc(total_cycles, 32'hFFFF_FFFF);
               if (m_ack) begin
                  m_wr <= 1'b0;
                  m_rd <= 1'b0;
`ifdef INTBUS_TRAFFIC_GEN_CHECK_EN
                  if (m_rd && m_rdata != m_wdata)
                     err_cnt <= CNT_W'(sat_inc(32'(err_cnt), 32'({CNT_W{1'b1}})));
`endif
                  if (!last) begin
                     idx     <= idx + CNT_W'(1);
                     m_addr  <= m_addr + ADDR_W'(ADDR_STEP);
                     m_wdata <= m_wdata + DATA_W'(1);
                     state   <= GAP;
                  end else if (two_pass && !rd_pass) begin
                     rd_pass <= 1'b1;
                     idx     <= '0;
                     m_addr  <= base_r;
                     m_wdata <= seed_r;
                     state   <= GAP;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end else if (lat_hit) begin
                  m_wr    <= 1'b0;
                  m_rd    <= 1'b0;
                  timeout <= 1'b1;
                  state   <= DONE;
                  done    <= 1'b1;
               end
            end
            GAP: begin
               total_cycles <= sat_inc(total_cycles, 32'hFFFF_FFFF);
               m_wr         <= !rd_pass;
               m_rd         <= rd_pass;
               state        <= REQ;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_intbus_traffic_gen.sv
// Scoreboard bench for intbus_traffic_gen with a memory-backed target model.
module tb_intbus_traffic_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] cfg_base;
   logic [15:0] cfg_count;
   logic [1:0]  cfg_mode;
   logic [31:0] cfg_seed;
   logic [15:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_wr, m_rd;
   logic        m_ack = 1'b0;
   logic [31:0] m_rdata = '0;
   logic        busy, done, timeout;
   logic [15:0] err_cnt, max_lat;
   logic [31:0] total_cycles;

   always #5 clk = ~clk;

   intbus_traffic_gen #(.ADDR_W(16), .DATA_W(32), .CNT_W(16), .ADDR_STEP(1), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset), .start(start), .cfg_base(cfg_base), .cfg_count(cfg_count),
      .cfg_mode(cfg_mode), .cfg_seed(cfg_seed), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_wr(m_wr), .m_rd(m_rd), .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy), .done(done),
      .timeout(timeout), .err_cnt(err_cnt), .max_lat(max_lat), .total_cycles(total_cycles)
   );

`ifdef INTBUS_TRAFFIC_GEN_CHECK_EN
   localparam int EXP_ERR = 1;
`else
   localparam int EXP_ERR = 0;
`endif

   int checks = 0;
   int failures = 0;
   logic [48:0] exp_q[$];

   // target model configuration
   int  delay_idx = -1, delay_val = 0, flip_idx = -1;
   bit  never_ack = 0;
   int  txn_cnt = 0, rd_cnt = 0, wait_cnt = 0;
   logic [31:0] mem [int];

   // monitor counters
   int done_cnt = 0, busy_cycles = 0, req_cycles = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // target: acks after the programmed wait, echoes memory on reads
   initial forever begin
      @(negedge clk);
      if ((m_wr || m_rd) && !never_ack &&
          wait_cnt == ((txn_cnt == delay_idx) ? delay_val : 0)) begin
         m_ack = 1'b1;
         if (m_wr) mem[int'(m_addr)] = m_wdata;
         else begin
            m_rdata = (mem.exists(int'(m_addr)) ? mem[int'(m_addr)] : 32'd0) ^
                      ((rd_cnt == flip_idx) ? 32'd1 : 32'd0);
            rd_cnt++;
         end
         txn_cnt++;
         wait_cnt = 0;
      end else begin
         m_ack = 1'b0;
         if (m_wr || m_rd) wait_cnt++;
         else wait_cnt = 0;
      end
   end

   // monitor: pops the scoreboard on each acknowledged request
   initial forever begin
      logic [48:0] e;
      @(negedge clk);
      #1;
      if (busy) busy_cycles++;
      if (done) done_cnt++;
      if (m_wr || m_rd) req_cycles++;
      if (m_wr && m_rd) chk("wr_rd_both", 1, 0);
      if ((m_wr || m_rd) && m_ack) begin
         if (exp_q.size() == 0) chk("unexpected_txn", {m_wr, m_addr, m_wdata}, 0);
         else begin
            e = exp_q.pop_front();
            chk("txn", {15'd0, m_wr, m_addr, m_wdata}, {15'd0, e});
         end
      end
   end

   task automatic push_pass(input bit wr, input logic [15:0] base, input int n, input logic [31:0] seed);
      for (int i = 0; i < n; i++) exp_q.push_back({wr, base + 16'(i), seed + 32'(i)});
   endtask

   task automatic kick(input logic [1:0] mode, input logic [15:0] base, input logic [15:0] cnt,
                       input logic [31:0] seed);
      txn_cnt = 0; rd_cnt = 0; wait_cnt = 0;
      done_cnt = 0; busy_cycles = 0; req_cycles = 0;
      @(negedge clk);
      cfg_mode = mode; cfg_base = base; cfg_count = cnt; cfg_seed = seed;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic finish_run(input string tag, input int exp_total, input int exp_max,
                             input int exp_err, input bit exp_to, input bit chk_max);
      for (int c = 0; c < 300 && done_cnt == 0; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk({tag, "_done_cnt"}, done_cnt, 1);
      chk({tag, "_busy_cycles"}, busy_cycles, exp_total);
      chk({tag, "_total_cycles"}, total_cycles, exp_total);
      chk({tag, "_err_cnt"}, err_cnt, exp_err);
      chk({tag, "_timeout"}, timeout, exp_to);
      chk({tag, "_busy_low"}, busy, 0);
      chk({tag, "_queue_empty"}, exp_q.size(), 0);
      if (chk_max) chk({tag, "_max_lat"}, max_lat, exp_max);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      cfg_base = '0; cfg_count = '0; cfg_mode = '0; cfg_seed = '0;
      repeat (3) @(negedge clk);
      chk("rst_outputs", {m_wr, m_rd, busy, done, timeout, err_cnt, max_lat}, 0);
      chk("rst_total", total_cycles, 0);
      chk("rst_addr", {m_addr, m_wdata}, 0);
      reset = 1'b0;
      @(negedge clk);

      // 4 writes, ack first cycle
      push_pass(1, 16'h10, 4, 32'hA0);
      kick(2'd0, 16'h10, 16'd4, 32'hA0);
      finish_run("wr4", 8, 1, 0, 0, 1);

      // write pass then read pass, echoing target
      push_pass(1, 16'h200, 3, 32'h1234_5678);
      push_pass(0, 16'h200, 3, 32'h1234_5678);
      kick(2'd2, 16'h200, 16'd3, 32'h1234_5678);
      finish_run("wr_rd", 12, 1, 0, 0, 1);

      // corrupt read 1 of a two-pass run
      flip_idx = 1;
      push_pass(1, 16'h300, 3, 32'hFFFF_FFFE);
      push_pass(0, 16'h300, 3, 32'hFFFF_FFFE);
      kick(2'd2, 16'h300, 16'd3, 32'hFFFF_FFFE);
      finish_run("flip", 12, 1, EXP_ERR, 0, 1);
      flip_idx = -1;

      // ack delayed 5 cycles on transaction 2, stray start mid-run ignored; mode 3 = writes
      delay_idx = 2; delay_val = 5;
      push_pass(1, 16'hFFFE, 4, 32'h50);
      kick(2'd3, 16'hFFFE, 16'd4, 32'h50);
      @(negedge clk);
      cfg_base = 16'h0099; cfg_count = 16'd9; cfg_mode = 2'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      finish_run("delay", 13, 6, 0, 0, 1);
      delay_idx = -1; delay_val = 0;

      // no ack ever: abort after 8 REQ cycles
      never_ack = 1;
      kick(2'd0, 16'h40, 16'd3, 32'h0);
      finish_run("tmo", 9, 0, 0, 1, 0);
      chk("tmo_req_cycles", req_cycles, 8);
      never_ack = 0;

      // zero count: straight to DONE, no bus activity, clears sticky timeout
      kick(2'd2, 16'h40, 16'd0, 32'h0);
      finish_run("cnt0", 1, 0, 0, 0, 1);
      chk("cnt0_req_cycles", req_cycles, 0);

      // reset in the middle of a request
      never_ack = 1;
      kick(2'd0, 16'h80, 16'd2, 32'h7);
      repeat (2) @(negedge clk);
      chk("mid_req_active", m_wr, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_req_low", {m_wr, m_rd}, 0);
      chk("mid_rst_status", {busy, done, timeout, err_cnt, max_lat}, 0);
      chk("mid_rst_total", total_cycles, 0);
      @(negedge clk);
      reset = 1'b0;
      never_ack = 0;
      repeat (5) @(negedge clk);
      chk("mid_rst_no_done", done_cnt, 0);
      chk("mid_rst_idle", {busy, m_wr, m_rd}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/intbus_traffic_gen.md
# intbus_traffic_gen

Bus-master traffic generator for the internal register bus: it issues a programmed sequence of single-beat writes and/or reads to a target address window and measures transaction latency and total run time. It is the initiator counterpart to the bus-slave performance/timer block, which it drives during bus throughput characterisation. It sits beside the CPU bridge on the debug path; its own configuration comes from a parent register block as plain ports.

## Interface
- ADDR_W, 16: master address width.
- DATA_W, 32: master data width.
- CNT_W, 16: transaction count width.
- ADDR_STEP, 1: address increment per transaction.
- TIMEOUT, 1024: max cycles waiting for ack before abort (>=2).
- clk  in  1  bus clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE, ignored otherwise.
- cfg_base  in  ADDR_W  first address.
- cfg_count  in  CNT_W  transactions per pass; 0 -> done immediately, no bus activity.
- cfg_mode  in  2  0 write pass, 1 read pass, 2 write pass then read pass, 3 treated as 0.
- cfg_seed  in  DATA_W  data pattern seed.
- m_addr  out  ADDR_W  request address.
- m_wdata  out  DATA_W  write data.
- m_wr  out  1  write request.
- m_rd  out  1  read request.
- m_ack  in  1  target acknowledge; for reads m_rdata valid in the same cycle.
- m_rdata  in  DATA_W  read data.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at run end.
- timeout  out  1  sticky; set on abort, cleared on next accepted start.
- err_cnt  out  CNT_W  read-data mismatches, saturating.
- max_lat  out  16  worst-case request-to-ack cycles, saturating.
- total_cycles  out  32  cycles from start acceptance to done, saturating.
- All outputs reset to 0.

## Operation
- FSM: IDLE -> REQ (start accepted; cfg_* captured, index=0, counters cleared) -> GAP (ack, more remaining) -> REQ; REQ -> DONE (ack on last transaction of last pass, or timeout); DONE -> IDLE unconditionally.
- Mode 2: after last write ack, index resets to 0 and read pass begins via GAP.
- Transaction i: m_addr = cfg_base + i*ADDR_STEP mod 2^ADDR_W; m_wdata = cfg_seed + i mod 2^DATA_W; expected read data identical.
- Exactly one of m_wr/m_rd high in REQ only; address/data stable for the whole REQ; m_ack outside REQ ignored.
- Latency = cycles in REQ including ack cycle (ack in first REQ cycle = 1); max_lat updated per transaction.
- Timeout: latency reaches TIMEOUT without ack -> request dropped, timeout=1, DONE; remaining transactions skipped.
- cfg_count=0: IDLE -> DONE directly, busy high one cycle.
- reset mid-run: request drops next edge, all state and outputs to 0, no done pulse.
- Status (err_cnt, max_lat, total_cycles, timeout) holds after DONE until next start.

## Timing
- start at edge N -> REQ, busy=1 at N+1; request visible same cycle.
- Ack at edge K -> GAP at K+1 (requests low exactly one cycle) -> next REQ at K+2.
- done pulses in DONE state, one cycle after final ack; busy falls with done.
- err_cnt/max_lat update the cycle after the ack.

## Configuration
- INTBUS_TRAFFIC_GEN_CHECK_EN defined: read data compared to expected in ack cycle, mismatch increments err_cnt.
- Undefined: no comparator, err_cnt tied 0; reads still issued and timed.

## Structure
- Shared package intbus_traffic_gen_pkg: state enum (IDLE, REQ, GAP, DONE), mode constants, saturating-increment function.
- One sub-module: intbus_lat_meter (latency counter, max tracker, saturation), instantiated once.

## Test plan
- Mode 0, base 0x10, count 4, seed 0xA0, ack first cycle -> writes 0x10..0x13 data 0xA0..0xA3, max_lat=1, done once, total_cycles=8.
- Mode 2, count 3, target echoes memory -> 3 writes then 3 reads same addresses, err_cnt=0.
- Check enabled, target returns data^1 on read 1 -> err_cnt=1; disabled build -> err_cnt=0.
- Ack delayed 5 cycles on transaction 2 -> max_lat=6; TIMEOUT=8 with ack never -> request drops after 8 cycles, timeout=1, done pulse.
- cfg_count=0 -> no m_wr/m_rd, busy 1 cycle, done pulse; start during busy ignored.
- reset asserted mid-REQ -> m_wr/m_rd low next cycle, all outputs 0, no done.
